state_duration_checker: RTL and testbench

//  Consumer of a random 1-bit state stream (state_o of the random state generator).

---
 rtl/state_check_pkg.sv | 19 +
 rtl/bit_synchronizer.sv | 24 ++
 rtl/state_duration_checker.sv | 157 +++++++++++++++
 tb/tb_state_duration_checker.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/state_check_pkg.sv
// Shared types and helpers for the state-stream run-length checker.
// Run records pair a level with its measured length and a bounds-violation flag.
package state_check_pkg;

  localparam int REC_CNT_W = 16;

  typedef struct packed {
    logic                 level;
    logic [REC_CNT_W-1:0] len;
    logic                 err;
  } run_rec_t;

  function automatic logic in_bounds(input int unsigned len,
                                     input int unsigned lo,
                                     input int unsigned hi);
    return (len >= lo) && (len <= hi);
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous bit; flops clear to 0 on reset.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic a_rst_n_i,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift chain; the oldest stage is the synchronised output.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/state_duration_checker.sv
// Measures every run of constant level on a 1-bit stream, checks it against per-level
// [MIN,MAX] bounds and emits one valid/ready record per completed run.
module state_duration_checker
  import state_check_pkg::*;
#(
  parameter int STATE_0_MIN_VAL = 10,
  parameter int STATE_0_MAX_VAL = 20,
  parameter int STATE_1_MIN_VAL = 30,
  parameter int STATE_1_MAX_VAL = 40,
  parameter int CNT_W           = 16,
  parameter int SYNC_STAGES     = 0
) (
  input  logic             clk_i,
  input  logic             a_rst_n_i,
  input  logic             state_i,
  input  logic             clear_i,
  output logic             meas_valid_o,
  input  logic             meas_ready_i,
  output logic             meas_level_o,
  output logic [CNT_W-1:0] meas_len_o,
  output logic             meas_err_o,
  output logic             err_min_o,
  output logic             err_max_o,
  output logic             drop_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  typedef struct packed {
    logic             level;
    logic [CNT_W-1:0] len;
    logic             err;
  } rec_t;

  localparam logic [CNT_W-1:0] MIN0_C    = CNT_W'(STATE_0_MIN_VAL);
  localparam logic [CNT_W-1:0] MAX0_C    = CNT_W'(STATE_0_MAX_VAL);
  localparam logic [CNT_W-1:0] MIN1_C    = CNT_W'(STATE_1_MIN_VAL);
  localparam logic [CNT_W-1:0] MAX1_C    = CNT_W'(STATE_1_MAX_VAL);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
  localparam longint           SAT_C     = (64'sd1 <<< CNT_W) - 64'sd1;

  // MAX must stay below saturation so the early-max point is always reachable.
  if ((STATE_0_MIN_VAL > STATE_0_MAX_VAL) || (STATE_1_MIN_VAL > STATE_1_MAX_VAL) ||
      (longint'(STATE_0_MAX_VAL) >= SAT_C) || (longint'(STATE_1_MAX_VAL) >= SAT_C) ||
      !((SYNC_STAGES == 0) || (SYNC_STAGES == 2) || (SYNC_STAGES == 3))) begin : g_param_err
    $error("state_duration_checker: illegal parameter combination");
  end

  logic s_s;
  if (SYNC_STAGES > 0) begin : g_sync
    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
      .clk_i     (clk_i),
      .a_rst_n_i (a_rst_n_i),
      .d         (state_i),
      .q         (s_s)
    );
  end else begin : g_nosync
    assign s_s = state_i;
  end

  logic             prev_r;
  logic [CNT_W-1:0] cnt_r;
  logic             first_run_r;
  rec_t             rec_r;
  logic             valid_r;
  logic             err_min_r;
  logic             err_max_r;
  logic             drop_r;
  logic [CNT_W-1:0] err_cnt_r;

  logic             same_s;
  logic [CNT_W-1:0] lo_s;
  logic [CNT_W-1:0] hi_s;
  logic             rec_due_s;
  logic             viol_min_s;
  logic             viol_max_s;
  logic             viol_s;
  logic             early_max_s;
  logic             pop_s;
  logic             load_s;
  logic             drop_now_s;

  // Run-end detection, bound selection by level, and record handshake decode.
  always_comb begin
    same_s      = (s_s == prev_r);
    lo_s        = prev_r ? MIN1_C : MIN0_C;
    hi_s        = prev_r ? MAX1_C : MAX0_C;
    rec_due_s   = !same_s && !first_run_r;
    viol_min_s  = rec_due_s && (cnt_r < lo_s);
    viol_max_s  = rec_due_s && (cnt_r > hi_s);
    viol_s      = rec_due_s && !in_bounds(int'(cnt_r), int'(lo_s), int'(hi_s));
    // Counter is about to step from MAX to MAX+1 inside a checked run.
    early_max_s = same_s && !first_run_r && (cnt_r == hi_s);
    pop_s       = valid_r && meas_ready_i;
    load_s      = rec_due_s && (!valid_r || pop_s);
    drop_now_s  = rec_due_s && valid_r && !meas_ready_i;
  end

  // Run-length counter, previous level and partial-first-run marker.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      prev_r      <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      first_run_r <= 1'b1;
    end else begin
      prev_r <= s_s;
      if (!same_s) begin
        cnt_r       <= ONE_C;
        first_run_r <= 1'b0;
      end else if (cnt_r != CNT_MAX_C) begin
        cnt_r <= cnt_r + ONE_C;
      end
    end
  end

  // Single-entry record register with valid/ready output handshake.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      rec_r   <= '{level: 1'b0, len: {CNT_W{1'b0}}, err: 1'b0};
      valid_r <= 1'b0;
    end else if (load_s) begin
      rec_r   <= '{level: prev_r, len: cnt_r, err: viol_s};
      valid_r <= 1'b1;
    end else if (pop_s) begin
      valid_r <= 1'b0;
    end
  end

  // Sticky flags and saturating violation count; a same-cycle event beats clear.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      err_min_r <= 1'b0;
      err_max_r <= 1'b0;
      drop_r    <= 1'b0;
      err_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (viol_min_s)                     err_min_r <= 1'b1;
      else if (clear_i)                   err_min_r <= 1'b0;
      if (viol_max_s || early_max_s)      err_max_r <= 1'b1;
      else if (clear_i)                   err_max_r <= 1'b0;
      if (drop_now_s)                     drop_r    <= 1'b1;
      else if (clear_i)                   drop_r    <= 1'b0;
      if (clear_i)                        err_cnt_r <= viol_s ? ONE_C : {CNT_W{1'b0}};
      else if (viol_s && (err_cnt_r != CNT_MAX_C)) err_cnt_r <= err_cnt_r + ONE_C;
    end
  end

  assign meas_valid_o = valid_r;
  assign meas_level_o = rec_r.level;
  assign meas_len_o   = rec_r.len;
  assign meas_err_o   = rec_r.err;
  assign err_min_o    = err_min_r;
  assign err_max_o    = err_max_r;
  assign drop_o       = drop_r;
  assign err_cnt_o    = err_cnt_r;

endmodule

// File: tb/tb_state_duration_checker.sv
// Directed + pseudo-random bench for state_duration_checker; expected run records are
// queued when a run is ended by the stimulus and compared when the DUT hands them over.
module tb_state_duration_checker;

  localparam int CW   = 8;
  localparam int MIN0 = 10;
  localparam int MAX0 = 20;
  localparam int MIN1 = 30;
  localparam int MAX1 = 40;
  localparam int SATV = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          a_rst_n_i;
  logic          state_i;
  logic          clear_i;
  logic          meas_valid_o;
  logic          meas_ready_i;
  logic          meas_level_o;
  logic [CW-1:0] meas_len_o;
  logic          meas_err_o;
  logic          err_min_o;
  logic          err_max_o;
  logic          drop_o;
  logic [CW-1:0] err_cnt_o;

  state_duration_checker #(
    .STATE_0_MIN_VAL (MIN0),
    .STATE_0_MAX_VAL (MAX0),
    .STATE_1_MIN_VAL (MIN1),
    .STATE_1_MAX_VAL (MAX1),
    .CNT_W           (CW),
    .SYNC_STAGES     (0)
  ) dut (
    .clk_i        (clk_i),
    .a_rst_n_i    (a_rst_n_i),
    .state_i      (state_i),
    .clear_i      (clear_i),
    .meas_valid_o (meas_valid_o),
    .meas_ready_i (meas_ready_i),
    .meas_level_o (meas_level_o),
    .meas_len_o   (meas_len_o),
    .meas_err_o   (meas_err_o),
    .err_min_o    (err_min_o),
    .err_max_o    (err_max_o),
    .drop_o       (drop_o),
    .err_cnt_o    (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  logic [CW+1:0] sb[$];
  logic          cur_level;
  int            cur_len;
  bit            first_tb;
  int            err_cnt_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Hold the stream at lvl for n sampling edges; queue the record of any run this ends.
  task automatic drive(input logic lvl, input int n);
    int  len;
    bit  err;
    if (lvl != cur_level) begin
      if (!first_tb) begin
        len = (cur_len > SATV) ? SATV : cur_len;
        err = cur_level ? ((len < MIN1) || (len > MAX1)) : ((len < MIN0) || (len > MAX0));
        if (err && (err_cnt_exp < SATV)) err_cnt_exp++;
        sb.push_back({cur_level, CW'(len), err});
      end
      first_tb  = 1'b0;
      cur_len   = 0;
      cur_level = lvl;
    end
    state_i = lvl;
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
    cur_len += n;
  endtask

  task automatic model_reset();
    cur_level   = 1'b0;
    cur_len     = 0;
    first_tb    = 1'b1;
    err_cnt_exp = 0;
  endtask

  // Scoreboard side: every accepted record must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (a_rst_n_i && meas_valid_o && meas_ready_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_record", {22'd0, meas_level_o, meas_len_o, meas_err_o}, 32'hFFFF_FFFF);
      end else begin
        chk("record", {22'd0, meas_level_o, meas_len_o, meas_err_o}, {22'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    int  cyc;
    logic lvl;
    a_rst_n_i    = 1'b0;
    state_i      = 1'b0;
    clear_i      = 1'b0;
    meas_ready_i = 1'b1;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", {31'd0, meas_valid_o}, 32'd0);
    chk("rst_flags", {29'd0, err_min_o, err_max_o, drop_o}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt_o}, 32'd0);
    chk("rst_rec", {22'd0, meas_level_o, meas_len_o, meas_err_o}, 32'd0);
    a_rst_n_i = 1'b1;

    // First 0-run is partial; the 35-cycle 1-run is the first record.
    drive(1'b0, 15);
    drive(1'b1, 35);
    drive(1'b0, 15);
    chk("t1_err_cnt", {24'd0, err_cnt_o}, 32'(err_cnt_exp));
    chk("t1_flags", {29'd0, err_min_o, err_max_o, drop_o}, 32'd0);

    // Short level-0 run.
    drive(1'b1, 35);
    drive(1'b0, 5);
    drive(1'b1, 35);
    chk("t2_err_min", {31'd0, err_min_o}, 32'd1);
    chk("t2_err_max", {31'd0, err_max_o}, 32'd0);
    chk("t2_err_cnt", {24'd0, err_cnt_o}, 32'(err_cnt_exp));

    // Long level-1 run: early max exactly on cycle 41.
    drive(1'b0, 15);
    drive(1'b1, 40);
    chk("t3_err_max_c40", {31'd0, err_max_o}, 32'd0);
    drive(1'b1, 1);
    chk("t3_err_max_c41", {31'd0, err_max_o}, 32'd1);
    drive(1'b1, 4);
    drive(1'b0, 15);
    chk("t3_err_cnt", {24'd0, err_cnt_o}, 32'(err_cnt_exp));

    // Back-pressure: second completed run is lost while the first is held.
    meas_ready_i = 1'b0;
    drive(1'b1, 35);
    drive(1'b0, 15);
    void'(sb.pop_back());
    chk("t4_drop", {31'd0, drop_o}, 32'd1);
    chk("t4_valid_held", {31'd0, meas_valid_o}, 32'd1);
    chk("t4_rec_held", {22'd0, meas_level_o, meas_len_o, meas_err_o}, {22'd0, sb[0]});
    meas_ready_i = 1'b1;
    drive(1'b0, 1);
    chk("t4_valid_drop", {31'd0, meas_valid_o}, 32'd0);

    // Clear pulse wipes flags and count.
    clear_i = 1'b1;
    drive(1'b0, 1);
    clear_i = 1'b0;
    err_cnt_exp = 0;
    chk("t6_clear_flags", {29'd0, err_min_o, err_max_o, drop_o}, 32'd0);
    chk("t6_clear_cnt", {24'd0, err_cnt_o}, 32'd0);

    // Counter saturation on an over-long level-1 run.
    drive(1'b1, (1 << CW) + 10);
    chk("t5_err_max", {31'd0, err_max_o}, 32'd1);
    drive(1'b0, 15);
    chk("t5_err_cnt", {24'd0, err_cnt_o}, 32'(err_cnt_exp));
    drive(1'b0, 5);
    chk("t5_sb_drained", 32'(sb.size()), 32'd0);

    // Reset in the middle of a run; the following run is partial again.
    a_rst_n_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("t6_rst_err_max", {31'd0, err_max_o}, 32'd0);
    chk("t6_rst_err_cnt", {24'd0, err_cnt_o}, 32'd0);
    chk("t6_rst_valid", {31'd0, meas_valid_o}, 32'd0);
    a_rst_n_i = 1'b1;
    drive(1'b0, 4);
    drive(1'b1, 35);
    drive(1'b0, 15);
    chk("t6_post_rst_cnt", {24'd0, err_cnt_o}, 32'd0);
    chk("t6_post_rst_min", {31'd0, err_min_o}, 32'd0);

    // Legal random stream: alternate levels with lengths inside their bounds.
    cyc = 0;
    lvl = 1'b1;
    while (cyc < 10000) begin
      int n;
      n = lvl ? int'($urandom_range(MAX1, MIN1)) : int'($urandom_range(MAX0, MIN0));
      drive(lvl, n);
      cyc += n;
      lvl = ~lvl;
    end
    chk("rand_err_cnt", {24'd0, err_cnt_o}, 32'd0);
    chk("rand_flags", {29'd0, err_min_o, err_max_o, drop_o}, 32'd0);
    chk("rand_sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
